// File: rtl/mmu_pkg.sv
// Types and defaults shared by the MMU array, the activation skew feeder and the psum deskew.
package mmu_pkg;
  localparam int MMU_DATA_WIDTH = 16;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} act_skew_state_e;
endpackage

// File: rtl/mmu_delay_line.sv
// Fixed-depth async-reset shift register; shifts every cycle, no enable.
module mmu_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/mmu_act_skew.sv
// Activation feeder for the systolic array's left edge: skews row r by r cycles,
// drains the skew after a tile's last beat and pulses done as it leaves the bottom row.
module mmu_act_skew
  import mmu_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int DATA_WIDTH = MMU_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_last,
  input  logic                       w_busy,
  output logic [ROWS*DATA_WIDTH-1:0] row_data,
  output logic [ROWS-1:0]            row_en,
  output logic                       busy,
  output logic                       done
);
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  act_skew_state_e  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             accept;

  assign in_ready = !w_busy && (state_q != DRAIN);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  // done is raised one cycle early so the registered pulse lines up with row ROWS-1
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, STREAM: begin
          if (accept) begin
            state_q <= in_last ? DRAIN : STREAM;
            cnt_q   <= CNT_W'(ROWS - 1);
          end
        end
        DRAIN: begin
          cnt_q  <= cnt_q - 1'b1;
          done_q <= (cnt_q == CNT_W'(1));
          if (cnt_q == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data is zeroed at the input on bubbles so every stage downstream reads 0 when en is 0
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_WIDTH-1:0] slice_d;
    logic [DATA_WIDTH:0]   din;
    logic [DATA_WIDTH:0]   dout;

    assign slice_d = accept ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
    assign din     = {accept, slice_d};

    mmu_delay_line #(
      .DEPTH(r + 1),
      .WIDTH(DATA_WIDTH + 1)
    ) u_dly (
      .clk (clk),
      .rstn(rstn),
      .d_i (din),
      .q_o (dout)
    );

    assign row_en[r]                              = dout[DATA_WIDTH];
    assign row_data[r*DATA_WIDTH +: DATA_WIDTH]   = dout[DATA_WIDTH-1:0];
  end
endmodule

// File: tb/tb_mmu_act_skew.sv
// Bench for mmu_act_skew: per-cycle history of accepted beats predicts rows, done, busy, ready.
module tb_mmu_act_skew;
  localparam int ROWS = 4;
  localparam int DW   = 16;
  localparam int W    = ROWS * DW;
  localparam int VW   = 3 + ROWS + W;
  localparam int HMAX = 8192;

  logic clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, in_last = 1'b0, w_busy = 1'b0;
  logic [W-1:0]    in_data = '0;
  logic            in_ready, busy, done;
  logic [W-1:0]    row_data;
  logic [ROWS-1:0] row_en;

  mmu_act_skew #(.ROWS(ROWS), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .w_busy(w_busy),
    .row_data(row_data), .row_en(row_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, errors = 0;

  // Reference model: what was accepted in each cycle, plus tile bookkeeping
  logic         acc_en   [HMAX];
  logic [W-1:0] acc_data [HMAX];
  int           t_last    = -1000;
  bit           tile_open = 1'b0;

  function automatic bit m_drain();
    return (cyc > t_last) && (cyc - t_last <= ROWS);
  endfunction

  function automatic logic [ROWS-1:0] m_en();
    logic [ROWS-1:0] e = '0;
    for (int r = 0; r < ROWS; r++) begin
      int idx = cyc - r - 1;
      if (idx >= 0 && acc_en[idx]) e[r] = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] m_data();
    logic [W-1:0] d = '0;
    for (int r = 0; r < ROWS; r++) begin
      int idx = cyc - r - 1;
      if (idx >= 0 && acc_en[idx]) d[r*DW +: DW] = acc_data[idx][r*DW +: DW];
    end
    return d;
  endfunction

  function automatic logic [VW-1:0] m_exp();
    logic rdy  = !w_busy && !m_drain();
    logic bsy  = tile_open || m_drain();
    logic dn   = ((cyc - t_last) == ROWS);
    return {rdy, bsy, dn, m_en(), m_data()};
  endfunction

  task automatic commit(output bit acc);
    acc = rstn && in_valid && !w_busy && !m_drain();
    acc_en[cyc]   = acc;
    acc_data[cyc] = in_data;
    if (acc) begin
      if (in_last) begin t_last = cyc; tile_open = 1'b0; end
      else tile_open = 1'b1;
    end
  endtask

  task automatic model_reset();
    t_last = -1000;
    tile_open = 1'b0;
    for (int i = 0; i <= cyc && i < HMAX; i++) acc_en[i] = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic l, input logic wb);
    @(posedge clk);
    #1;
    in_valid = v; in_data = d; in_last = l; w_busy = wb;
  endtask

  function automatic logic [W-1:0] pat(input int k);
    logic [W-1:0] d = '0;
    for (int r = 0; r < ROWS; r++) d[r*DW +: DW] = DW'(16 * k + r);
    return d;
  endfunction

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    logic [VW-1:0] got, exp;
    bit acc;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, rnd(), 1'b0, i == 2);
      if (i == 3) rstn = 1'b1;
      @(negedge clk);
      exp = m_exp(); got = {in_ready, busy, done, row_en, row_data}; vectors++;
      if (got !== exp) begin errors++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, got, exp); end
      commit(acc);
    end
  endtask

  task automatic test_single_beat();
    logic [VW-1:0] got, exp;
    bit acc;
    logic [W-1:0] v = 64'h0004_0003_0002_0001;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive(1'b1, v, 1'b1, 1'b0);
      else        drive(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      exp = m_exp(); got = {in_ready, busy, done, row_en, row_data}; vectors++;
      if (got !== exp) begin errors++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, got, exp); end
      commit(acc);
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] got, exp;
    bit acc;
    for (int i = 0; i < 10; i++) begin
      if (i < 3) drive(1'b1, pat(i), i == 2, 1'b0);
      else       drive(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      exp = m_exp(); got = {in_ready, busy, done, row_en, row_data}; vectors++;
      if (got !== exp) begin errors++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, got, exp); end
      commit(acc);
    end
  endtask

  task automatic test_bubble();
    logic [VW-1:0] got, exp;
    bit acc;
    for (int i = 0; i < 9; i++) begin
      if (i == 0 || i == 2) drive(1'b1, rnd(), i == 2, 1'b0);
      else                  drive(1'b0, rnd(), 1'b1, 1'b0);
      @(negedge clk);
      exp = m_exp(); got = {in_ready, busy, done, row_en, row_data}; vectors++;
      if (got !== exp) begin errors++; $display("FAIL bubble cyc=%0d got=%h exp=%h", cyc, got, exp); end
      commit(acc);
    end
  endtask

  task automatic test_w_busy();
    logic [VW-1:0] got, exp;
    logic [W-1:0] beats [3];
    bit acc;
    int nxt = 0;
    for (int k = 0; k < 3; k++) beats[k] = rnd();
    for (int i = 0; i < 14; i++) begin
      if (nxt < 3) drive(1'b1, beats[nxt], nxt == 2, (i >= 1 && i <= 3));
      else         drive(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      exp = m_exp(); got = {in_ready, busy, done, row_en, row_data}; vectors++;
      if (got !== exp) begin errors++; $display("FAIL wbusy cyc=%0d got=%h exp=%h", cyc, got, exp); end
      commit(acc);
      if (acc) nxt++;
    end
    vectors++;
    if (nxt !== 3) begin errors++; $display("FAIL wbusy_count got=%0d exp=3", nxt); end
  endtask

  task automatic test_reset_in_drain();
    logic [VW-1:0] got, exp;
    bit acc;
    for (int i = 0; i < 15; i++) begin
      if (i == 0 || i == 6) drive(1'b1, 64'h0004_0003_0002_0001, 1'b1, 1'b0);
      else                  drive(1'b0, '0, 1'b0, 1'b0);
      if (i == 3) begin rstn = 1'b0; model_reset(); end
      if (i == 5) rstn = 1'b1;
      @(negedge clk);
      exp = m_exp(); got = {in_ready, busy, done, row_en, row_data}; vectors++;
      if (got !== exp) begin errors++; $display("FAIL rst_drain cyc=%0d got=%h exp=%h", cyc, got, exp); end
      commit(acc);
    end
  endtask

  task automatic test_valid_in_drain();
    logic [VW-1:0] got, exp;
    logic [W-1:0] b = rnd();
    bit acc;
    int t0 = -1, t_acc = -1;
    for (int i = 0; i < 14; i++) begin
      if (i == 0)          drive(1'b1, rnd(), 1'b1, 1'b0);
      else if (t_acc < 0)  drive(1'b1, b, 1'b1, 1'b0);
      else                 drive(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      exp = m_exp(); got = {in_ready, busy, done, row_en, row_data}; vectors++;
      if (got !== exp) begin errors++; $display("FAIL drain_valid cyc=%0d got=%h exp=%h", cyc, got, exp); end
      commit(acc);
      if (acc && i == 0) t0 = cyc;
      else if (acc && t_acc < 0) t_acc = cyc;
    end
    vectors++;
    if (t_acc - t0 !== ROWS + 1) begin
      errors++; $display("FAIL drain_valid_latency got=%0d exp=%0d", t_acc - t0, ROWS + 1);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] got, exp;
    logic [W-1:0] pd = '0;
    bit pv = 1'b0, pl = 1'b0, acc;
    int rst_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pv && $urandom_range(0, 9) < 7) begin
        pv = 1'b1; pd = rnd(); pl = ($urandom_range(0, 3) == 0);
      end
      drive(pv, pv ? pd : rnd(), pv ? pl : 1'($urandom), ($urandom_range(0, 4) == 0));
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rstn = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        rstn = 1'b0; model_reset(); rst_cnt = 2;
      end
      @(negedge clk);
      exp = m_exp(); got = {in_ready, busy, done, row_en, row_data}; vectors++;
      if (got !== exp) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp); end
      commit(acc);
      if (acc) pv = 1'b0;
    end
    rstn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < HMAX; i++) begin acc_en[i] = 1'b0; acc_data[i] = '0; end
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_bubble();
    test_w_busy();
    test_reset_in_drain();
    test_valid_in_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
